// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline.
// Captures register file read data, decoded fields, the sign-extended
// immediate and main-control bits for EX. It also detects load-use hazards,
// applies branch flushes and keeps saturating debug counters.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instr_id,
    input  logic [31:0]      pc4_id,
    input  logic [31:0]      RdData1,
    input  logic [31:0]      RdData2,
    input  logic             RegWrite_id,
    input  logic             MemtoReg_id,
    input  logic             MemRead_id,
    input  logic             MemWrite_id,
    input  logic             ALUSrc_id,
    input  logic             RegDst_id,
    input  logic [1:0]       ALUOp_id,
    input  logic             flush,
    output logic             stall,
    output logic [31:0]      RdData1_ex,
    output logic [31:0]      RdData2_ex,
    output logic [31:0]      imm_ex,
    output logic [31:0]      pc4_ex,
    output logic [4:0]       rs_ex,
    output logic [4:0]       rt_ex,
    output logic [4:0]       rd_ex,
    output logic             RegWrite_ex,
    output logic             MemtoReg_ex,
    output logic             MemRead_ex,
    output logic             MemWrite_ex,
    output logic             ALUSrc_ex,
    output logic             RegDst_ex,
    output logic [1:0]       ALUOp_ex,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [4:0] rsId;
    logic [4:0] rtId;
    logic [4:0] rdId;
    logic       unusedOpcode;

    assign rsId = instr_id[25:21];
    assign rtId = instr_id[20:16];
    assign rdId = instr_id[15:11];
    // The opcode is decoded upstream; this stage never looks at it.
    assign unusedOpcode = ^instr_id[31:26];

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    // The rt match is deliberately conservative for I-type instructions.
    always_comb begin
        stall = 1'b0;
        if (!reset && !flush && MemRead_ex && (rt_ex != 5'd0) &&
            ((rt_ex == rsId) || (rt_ex == rtId))) begin
            stall = 1'b1;
        end
    end

    // Pipeline register: reset, then flush, then stall (both load a bubble), else capture.
    always_ff @(posedge clock) begin
        if (reset || flush || stall) begin
            RdData1_ex  <= '0;
            RdData2_ex  <= '0;
            imm_ex      <= '0;
            pc4_ex      <= '0;
            rs_ex       <= '0;
            rt_ex       <= '0;
            rd_ex       <= '0;
            RegWrite_ex <= 1'b0;
            MemtoReg_ex <= 1'b0;
            MemRead_ex  <= 1'b0;
            MemWrite_ex <= 1'b0;
            ALUSrc_ex   <= 1'b0;
            RegDst_ex   <= 1'b0;
            ALUOp_ex    <= '0;
        end else begin
            RdData1_ex  <= RdData1;
            RdData2_ex  <= RdData2;
            imm_ex      <= {{16{instr_id[15]}}, instr_id[15:0]};
            pc4_ex      <= pc4_id;
            rs_ex       <= rsId;
            rt_ex       <= rtId;
            rd_ex       <= rdId;
            RegWrite_ex <= RegWrite_id;
            MemtoReg_ex <= MemtoReg_id;
            MemRead_ex  <= MemRead_id;
            MemWrite_ex <= MemWrite_id;
            ALUSrc_ex   <= ALUSrc_id;
            RegDst_ex   <= RegDst_id;
            ALUOp_ex    <= ALUOp_id;
        end
    end

    // Saturating debug counters; stall is already masked by flush, so only one counts per cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes hand-computed
// expectations per cycle, a separate monitor pops and compares them.
module tb_id_ex_stage;

    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   instr_id, pc4_id, RdData1, RdData2;
    logic          RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id, ALUSrc_id, RegDst_id;
    logic [1:0]    ALUOp_id;
    logic          flush;
    logic          stall;
    logic [31:0]   RdData1_ex, RdData2_ex, imm_ex, pc4_ex;
    logic [4:0]    rs_ex, rt_ex, rd_ex;
    logic          RegWrite_ex, MemtoReg_ex, MemRead_ex, MemWrite_ex, ALUSrc_ex, RegDst_ex;
    logic [1:0]    ALUOp_ex;
    logic [CW-1:0] stall_count, flush_count;

    id_ex_stage #(.CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .instr_id(instr_id), .pc4_id(pc4_id),
        .RdData1(RdData1), .RdData2(RdData2),
        .RegWrite_id(RegWrite_id), .MemtoReg_id(MemtoReg_id), .MemRead_id(MemRead_id),
        .MemWrite_id(MemWrite_id), .ALUSrc_id(ALUSrc_id), .RegDst_id(RegDst_id),
        .ALUOp_id(ALUOp_id), .flush(flush), .stall(stall),
        .RdData1_ex(RdData1_ex), .RdData2_ex(RdData2_ex), .imm_ex(imm_ex), .pc4_ex(pc4_ex),
        .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
        .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex), .MemRead_ex(MemRead_ex),
        .MemWrite_ex(MemWrite_ex), .ALUSrc_ex(ALUSrc_ex), .RegDst_ex(RegDst_ex),
        .ALUOp_ex(ALUOp_ex), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    // ctrl packing: {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}
    typedef struct {
        logic          stall;
        logic [7:0]    ctrl;
        logic [4:0]    rs, rt, rd;
        logic [31:0]   imm, d1, d2, pc4;
        logic [CW-1:0] sc, fc;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    localparam logic [31:0] LW   = 32'h8C08FFFC; // lw  $t0,-4($zero)
    localparam logic [31:0] ADD  = 32'h010A4820; // add $t1,$t0,$t2
    localparam logic [31:0] LWZ  = 32'h8D000004; // lw  $zero,4($t0)
    localparam logic [31:0] ADDZ = 32'h00004820; // add $t1,$zero,$zero
    localparam logic [7:0]  C_LW = 8'hE8;
    localparam logic [7:0]  C_R  = 8'h86;

    function automatic exp_t outs(logic [7:0] c, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                                  logic [31:0] im, logic [31:0] a, logic [31:0] b, logic [31:0] p);
        exp_t e;
        e.stall = 1'b0; e.ctrl = c; e.rs = s; e.rt = t; e.rd = d;
        e.imm = im; e.d1 = a; e.d2 = b; e.pc4 = p; e.sc = '0; e.fc = '0;
        return e;
    endfunction

    task automatic step(input logic rst, input logic fl, input logic [31:0] ins,
                        input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] c, input exp_t e, input logic expStall,
                        input logic [CW-1:0] sc, input logic [CW-1:0] fc);
        exp_t x;
        @(negedge clock);
        reset = rst; flush = fl; instr_id = ins; pc4_id = p; RdData1 = a; RdData2 = b;
        {RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id, ALUSrc_id, RegDst_id, ALUOp_id} = c;
        x = e; x.stall = expStall; x.sc = sc; x.fc = fc;
        expQ.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: stall is checked mid-cycle once inputs settle, registers just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                chk("stall", 32'(stall), 32'(e.stall));
                @(posedge clock);
                #1;
                chk("ctrl", 32'({RegWrite_ex, MemtoReg_ex, MemRead_ex, MemWrite_ex,
                                 ALUSrc_ex, RegDst_ex, ALUOp_ex}), 32'(e.ctrl));
                chk("rs_ex", 32'(rs_ex), 32'(e.rs));
                chk("rt_ex", 32'(rt_ex), 32'(e.rt));
                chk("rd_ex", 32'(rd_ex), 32'(e.rd));
                chk("imm_ex", imm_ex, e.imm);
                chk("RdData1_ex", RdData1_ex, e.d1);
                chk("RdData2_ex", RdData2_ex, e.d2);
                chk("pc4_ex", pc4_ex, e.pc4);
                chk("stall_count", 32'(stall_count), 32'(e.sc));
                chk("flush_count", 32'(flush_count), 32'(e.fc));
            end
        end
    end

    initial begin
        exp_t bub, eLw, eAdd, eLwz, eAddz;
        logic [CW-1:0] sc;
        int waitCycles;
        bub   = outs(8'h00, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0);
        eLw   = outs(C_LW,  5'd0, 5'd8,  5'd31, 32'hFFFFFFFC, 32'h11111111, 32'h22222222, 32'h10);
        eAdd  = outs(C_R,   5'd8, 5'd10, 5'd9,  32'h00004820, 32'h33333333, 32'h44444444, 32'h14);
        eLwz  = outs(C_LW,  5'd8, 5'd0,  5'd0,  32'h00000004, 32'h55555555, 32'h0,        32'h18);
        eAddz = outs(C_R,   5'd0, 5'd0,  5'd9,  32'h00004820, 32'h0,        32'h0,        32'h1C);

        reset = 1'b1; flush = 1'b0; instr_id = '0; pc4_id = '0; RdData1 = '0; RdData2 = '0;
        {RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id, ALUSrc_id, RegDst_id, ALUOp_id} = '0;

        // Reset with random inputs (including random flush): everything cleared.
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom), $urandom, $urandom, $urandom, $urandom, 8'($urandom),
                 bub, 1'b0, 0, 0);

        // Pass-through of the lw.
        step(0, 0, LW,  32'h10, 32'h11111111, 32'h22222222, C_LW, eLw,  1'b0, 0, 0);
        // Dependent add: one stall cycle with a bubble, then captured.
        step(0, 0, ADD, 32'h14, 32'h33333333, 32'h44444444, C_R,  bub,  1'b1, 1, 0);
        step(0, 0, ADD, 32'h14, 32'h33333333, 32'h44444444, C_R,  eAdd, 1'b0, 1, 0);
        // Load into $zero followed by a reader of $zero: never a stall.
        step(0, 0, LWZ,  32'h18, 32'h55555555, 32'h0, C_LW, eLwz,  1'b0, 1, 0);
        step(0, 0, ADDZ, 32'h1C, 32'h0,        32'h0, C_R,  eAddz, 1'b0, 1, 0);
        // Flush on top of a load-use condition: flush wins.
        step(0, 0, LW,  32'h10, 32'h11111111, 32'h22222222, C_LW, eLw,  1'b0, 1, 0);
        step(0, 1, ADD, 32'h14, 32'h33333333, 32'h44444444, C_R,  bub,  1'b0, 1, 1);
        step(0, 0, ADD, 32'h14, 32'h33333333, 32'h44444444, C_R,  eAdd, 1'b0, 1, 1);

        // Ten more load-use stalls: the 3-bit stall counter saturates at 7.
        sc = 3'd1;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, LW,  32'h10, 32'h11111111, 32'h22222222, C_LW, eLw, 1'b0, sc, 1);
            if (sc != 3'd7) sc = sc + 3'd1;
            step(0, 0, ADD, 32'h14, 32'h33333333, 32'h44444444, C_R,  bub, 1'b1, sc, 1);
        end
        // Reset with a pending load-use condition: stall masked, all cleared.
        step(0, 0, LW,  32'h10, 32'h11111111, 32'h22222222, C_LW, eLw, 1'b0, 3'd7, 1);
        step(1, 0, ADD, 32'h14, 32'h33333333, 32'h44444444, C_R,  bub, 1'b0, 0, 0);
        step(0, 0, ADD, 32'h14, 32'h33333333, 32'h44444444, C_R,  eAdd, 1'b0, 0, 0);

        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 20) begin
            @(posedge clock);
            waitCycles++;
        end
        repeat (2) @(posedge clock);
        if (expQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS pipeline. It sits directly downstream of the register file.
- Each cycle it captures the register file read data (RdData1/RdData2), the decoded fields, the sign-extended immediate and the main-control bits, and presents them to EX.
- It contains the load-use hazard detector. The detector stalls PC/IF-ID and inserts a bubble into EX.
- It applies branch flushes and keeps saturating stall and flush counters for debug readout.

Parameters:
- CNT_W, 16, width of the stall_count and flush_count saturating counters.

Ports:
- clock  input  1  system clock; all state updates on posedge (the register file writes on negedge, so same-cycle WB data is visible on RdData1/2).
- reset  input  1  synchronous, active-high.
- instr_id  input  32  instruction in ID; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- pc4_id  input  32  PC+4 of the ID instruction.
- RdData1  input  32  register file read port 1 (rs).
- RdData2  input  32  register file read port 2 (rt).
- RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id, ALUSrc_id, RegDst_id  input  1 each  main-control outputs for the ID instruction.
- ALUOp_id  input  2  ALU op class.
- flush  input  1  branch/jump taken; the ID instruction must be squashed.
- stall  output  1  combinational; 1 freezes PC and IF/ID.
- RdData1_ex, RdData2_ex, imm_ex, pc4_ex  output  32 each  registered data to EX.
- rs_ex, rt_ex, rd_ex  output  5 each  registered register numbers (to forwarding unit and RegDst mux).
- RegWrite_ex, MemtoReg_ex, MemRead_ex, MemWrite_ex, ALUSrc_ex, RegDst_ex  output  1 each  registered control.
- ALUOp_ex  output  2  registered ALU op class.
- stall_count  output  CNT_W  number of stall cycles since reset, saturating.
- flush_count  output  CNT_W  number of flush cycles since reset, saturating.

Behaviour:
- Reset (clock edge with reset=1): every registered output goes to 0, which equals a bubble (nop: all control 0, data 0). Both counters go to 0. reset overrides flush and stall on that edge.
- Hazard detection is combinational from the registered EX state and instr_id:
  - stall = !reset && !flush && MemRead_ex && (rt_ex != 0) && (rt_ex == instr_id[25:21] || rt_ex == instr_id[20:16]).
  - The rt comparison is unconditional: a conservative stall for I-type instructions is acceptable.
- Per posedge, in priority order:
  1. reset: clear as above.
  2. flush=1: load a bubble. All control outputs and data/register-number outputs are 0. flush_count increments.
  3. stall=1: load a bubble into EX; the ID instruction is held upstream and re-presented next cycle. stall_count increments.
  4. Otherwise, normal capture:
     - RdData1_ex←RdData1, RdData2_ex←RdData2, pc4_ex←pc4_id.
     - imm_ex←{{16{instr_id[15]}}, instr_id[15:0]}.
     - rs_ex/rt_ex/rd_ex←instr fields.
     - All *_ex control bits←*_id.
- Latency: exactly 1 cycle from ID inputs to *_ex outputs.
- Load-use timing: an lw followed by a dependent instruction gives exactly one stall cycle. In the next cycle the bubble has MemRead_ex=0, so stall drops and the dependent instruction is captured. Forwarding from MEM/WB is handled downstream.
- Simultaneous flush and stall condition: flush wins, stall output is 0, and only flush_count increments.
- Counters: increment by 1 per qualifying cycle. Each holds at 2^CNT_W−1 once reached; there is no wrap.
- No internal FSM beyond the pipeline register. Two consecutive stalls cannot occur from a single lw, because a bubble is never a load.

Test Plan:
- Reset: assert reset 2 cycles with random inputs → all *_ex = 0, stall=0, stall_count=flush_count=0.
- Pass-through: instr_id=0x8C08FFFC (lw $t0,-4($zero)), RdData1=0x11111111, RdData2=0x22222222, pc4_id=0x00000010, MemRead_id=MemtoReg_id=RegWrite_id=ALUSrc_id=1, ALUOp_id=00 → next cycle imm_ex=0xFFFFFFFC, rs_ex=0, rt_ex=8, RdData1_ex=0x11111111, pc4_ex=0x10, MemRead_ex=1.
- Load-use: the above lw, then add $t1,$t0,$t2 (0x010A4820) in ID → stall=1 for exactly 1 cycle, EX gets a bubble (RegWrite_ex=0), then the add is captured with rs_ex=8; stall_count=1.
- No false stall: lw into $zero (rt=0), then an instruction reading $zero → stall=0 throughout.
- Flush priority: load-use condition present and flush=1 in the same cycle → stall=0, bubble loaded, flush_count=1, stall_count unchanged.
- Saturation: CNT_W=3, force 10 load-use stalls → stall_count stops at 7. Reset mid-sequence → stall_count=0 on the next cycle.
